// File: rtl/mul4_tournament_sched_if.sv
// Bus between the tournament scheduler and the candidate mux/host side.
// The master modport is the scheduler; the slave modport is the candidate mux and host.
interface mul4_tournament_sched_if #(
  parameter int N_CAND = 4
);
  localparam int IDX_W = (N_CAND > 1) ? $clog2(N_CAND) : 1;

  logic             start;
  logic             busy;
  logic             done;
  logic [15:0]      a1;
  logic [15:0]      a0;
  logic [15:0]      b1;
  logic [15:0]      b0;
  logic [IDX_W-1:0] cand_sel;
  logic [15:0]      y3;
  logic [15:0]      y2;
  logic [15:0]      y1;
  logic [15:0]      y0;
  logic [IDX_W-1:0] winner;
  logic [6:0]       best_fit;
  logic             perfect;

  modport master (
    input  start, y3, y2, y1, y0,
    output busy, done, a1, a0, b1, b0, cand_sel, winner, best_fit, perfect
  );

  modport slave (
    output start, y3, y2, y1, y0,
    input  busy, done, a1, a0, b1, b0, cand_sel, winner, best_fit, perfect
  );
endinterface

// File: rtl/mul4_tournament_sched.sv
// Tournament sequencer/scorer for 2x2-bit multiplier candidates driven with 16-lane truth-table vectors.
// Optional macro MUL4_SCHED_EARLY_EXIT_EN ends the round at the first perfect (64/64) candidate.
module mul4_tournament_sched #(
  parameter int N_CAND = 4,
  parameter int SETTLE = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  mul4_tournament_sched_if.master       bus,
  output logic [2:0]                    state_dbg
);
  localparam int IDX_W = (N_CAND > 1) ? $clog2(N_CAND) : 1;
  localparam logic [3:0]       SETTLE_LAST = (SETTLE > 1) ? 4'(SETTLE - 1) : 4'd0;
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(N_CAND - 1);

  localparam logic [15:0] G3 = 16'h8000;
  localparam logic [15:0] G2 = 16'h4C00;
  localparam logic [15:0] G1 = 16'h6AC0;
  localparam logic [15:0] G0 = 16'hA0A0;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_SAMPLE = 3'd2,
    S_UPDATE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0] sel_q, sel_d;
  logic [6:0]       fit_q, fit_d;
  logic [6:0]       best_q, best_d;
  logic [IDX_W-1:0] win_q, win_d;

  logic [63:0] mism;
  logic [6:0]  miss_cnt;
  logic [6:0]  sample_fit;

  // Handshake: start is sampled only in IDLE (ignored elsewhere, never queued);
  // busy is high in WAIT/SAMPLE/UPDATE; done is a single-cycle pulse in DONE,
  // and winner/best_fit/perfect/cand_sel hold from then until the next start.

  assign bus.a1 = 16'hCCCC;
  assign bus.a0 = 16'hAAAA;
  assign bus.b1 = 16'hFF00;
  assign bus.b0 = 16'hF0F0;

  // Every set bit is one lane/output bit where the candidate disagrees with the golden product.
  assign mism = {bus.y0 ^ G0, bus.y1 ^ G1, bus.y2 ^ G2, bus.y3 ^ G3};

  always_comb begin
    miss_cnt = '0;
    for (int i = 0; i < 64; i++) begin
      miss_cnt = miss_cnt + 7'(mism[i]);
    end
    sample_fit = 7'd64 - miss_cnt;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    fit_d   = fit_q;
    best_d  = best_q;
    win_d   = win_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          sel_d   = '0;
          best_d  = '0;
          win_d   = '0;
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // SETTLE of 0 still spends one cycle here so the mux output is stable.
        if (cnt_q >= SETTLE_LAST) begin
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_SAMPLE: begin
        fit_d   = sample_fit;
        state_d = S_UPDATE;
      end
      S_UPDATE: begin
        if ((fit_q > best_q) || (sel_q == '0)) begin
          best_d = fit_q;
          win_d  = sel_q;
        end
        if (sel_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          sel_d   = sel_q + IDX_W'(1);
          cnt_d   = '0;
          state_d = S_WAIT;
        end
`ifdef MUL4_SCHED_EARLY_EXIT_EN
        if (fit_q == 7'd64) begin
          sel_d   = sel_q;
          cnt_d   = cnt_q;
          state_d = S_DONE;
        end
`endif
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      fit_q   <= '0;
      best_q  <= '0;
      win_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      fit_q   <= fit_d;
      best_q  <= best_d;
      win_q   <= win_d;
    end
  end

  assign bus.busy     = (state_q == S_WAIT) || (state_q == S_SAMPLE) || (state_q == S_UPDATE);
  assign bus.done     = (state_q == S_DONE);
  assign bus.cand_sel = sel_q;
  assign bus.winner   = win_q;
  assign bus.best_fit = best_q;
  assign bus.perfect  = (best_q == 7'd64);
  assign state_dbg    = state_q;
endmodule

// File: tb/tb_mul4_tournament_sched.sv
// Bench for mul4_tournament_sched: directed and random rounds on a 4-candidate/SETTLE=1
// instance and a 1-candidate/SETTLE=0 instance, scored by an arithmetic reference model.
module tb_mul4_tournament_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int tests_run = 0;
  int fails     = 0;

  mul4_tournament_sched_if #(.N_CAND(4)) bus_a ();
  mul4_tournament_sched_if #(.N_CAND(1)) bus_b ();
  logic [2:0] st_a;
  logic [2:0] st_b;

  mul4_tournament_sched #(.N_CAND(4), .SETTLE(1)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a), .state_dbg(st_a)
  );
  mul4_tournament_sched #(.N_CAND(1), .SETTLE(0)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b), .state_dbg(st_b)
  );

  // Candidate pools; the external mux routes the selected candidate to y.
  logic [15:0] ya [4][4];
  logic [15:0] yb [2][4];
  logic start_a = 1'b0;
  logic start_b = 1'b0;

  assign bus_a.start = start_a;
  assign bus_b.start = start_b;
  assign bus_a.y3 = ya[bus_a.cand_sel][3];
  assign bus_a.y2 = ya[bus_a.cand_sel][2];
  assign bus_a.y1 = ya[bus_a.cand_sel][1];
  assign bus_a.y0 = ya[bus_a.cand_sel][0];
  assign bus_b.y3 = yb[bus_b.cand_sel][3];
  assign bus_b.y2 = yb[bus_b.cand_sel][2];
  assign bus_b.y1 = yb[bus_b.cand_sel][1];
  assign bus_b.y0 = yb[bus_b.cand_sel][0];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Golden product bit k over the 16 lanes: lane i has a = i%4, b = i/4.
  function automatic logic [15:0] golden(input int k);
    logic [15:0] g;
    g = '0;
    for (int i = 0; i < 16; i++) begin
      int p;
      p = (i % 4) * (i / 4);
      g[i] = ((p >> k) & 1) == 1;
    end
    return g;
  endfunction

  function automatic int model_fit(input logic [15:0] v3, input logic [15:0] v2,
                                   input logic [15:0] v1, input logic [15:0] v0);
    int m;
    m = 0;
    for (int i = 0; i < 16; i++) begin
      int p;
      p = (i % 4) * (i / 4);
      if (v3[i] == (((p >> 3) & 1) == 1)) m++;
      if (v2[i] == (((p >> 2) & 1) == 1)) m++;
      if (v1[i] == (((p >> 1) & 1) == 1)) m++;
      if (v0[i] == ((p & 1) == 1))        m++;
    end
    return m;
  endfunction

  task automatic set_cand(input int which, input int c, input logic [15:0] v3,
                          input logic [15:0] v2, input logic [15:0] v1, input logic [15:0] v0);
    if (which == 1) begin
      yb[c][3] = v3; yb[c][2] = v2; yb[c][1] = v1; yb[c][0] = v0;
    end else begin
      ya[c][3] = v3; ya[c][2] = v2; ya[c][1] = v1; ya[c][0] = v0;
    end
  endtask

  task automatic set_golden(input int which, input int c);
    set_cand(which, c, golden(3), golden(2), golden(1), golden(0));
  endtask

  task automatic set_start(input int which, input logic v);
    if (which == 1) start_b = v;
    else start_a = v;
  endtask

  function automatic logic [31:0] o_done(input int which);
    return (which == 1) ? 32'(bus_b.done) : 32'(bus_a.done);
  endfunction
  function automatic logic [31:0] o_busy(input int which);
    return (which == 1) ? 32'(bus_b.busy) : 32'(bus_a.busy);
  endfunction

  // One full round: model expectation first, then drive start and watch every cycle.
  task automatic run_round(input string name, input int which, input bit mid_start);
    int n, settle, per, lat, fsel, best, win, first64, done_at, pulses, busy_err;
    int fits[4];
    n      = (which == 1) ? 1 : 4;
    settle = (which == 1) ? 0 : 1;
    best = -1; win = 0; first64 = -1;
    for (int c = 0; c < n; c++) begin
      if (which == 1) fits[c] = model_fit(yb[c][3], yb[c][2], yb[c][1], yb[c][0]);
      else            fits[c] = model_fit(ya[c][3], ya[c][2], ya[c][1], ya[c][0]);
      if (fits[c] > best) begin best = fits[c]; win = c; end
      if (fits[c] == 64 && first64 < 0) first64 = c;
    end
    per  = ((settle > 1) ? settle : 1) + 2;
    lat  = n * per + 1;
    fsel = n - 1;
`ifdef MUL4_SCHED_EARLY_EXIT_EN
    if (first64 >= 0) begin
      lat  = (first64 + 1) * per + 1;
      fsel = first64;
    end
`endif
    @(negedge clk);
    set_start(which, 1'b1);
    @(posedge clk); #1;
    done_at = -1; pulses = 0; busy_err = 0;
    for (int cyc = 1; cyc <= lat + 4; cyc++) begin
      if (cyc > 1) begin @(posedge clk); #1; end
      set_start(which, mid_start && (cyc == 2 || cyc == lat));
      if (o_done(which) == 32'd1) begin
        pulses++;
        if (done_at < 0) done_at = cyc;
      end
      if (o_busy(which) != ((cyc < lat) ? 32'd1 : 32'd0)) busy_err++;
    end
    set_start(which, 1'b0);
    check({name, " done_cycle"}, 32'(done_at), 32'(lat));
    check({name, " done_pulses"}, 32'(pulses), 32'd1);
    check({name, " busy_profile_errs"}, 32'(busy_err), 32'd0);
    if (which == 1) begin
      check({name, " winner"}, 32'(bus_b.winner), 32'(win));
      check({name, " best_fit"}, 32'(bus_b.best_fit), 32'(best));
      check({name, " perfect"}, 32'(bus_b.perfect), 32'(best == 64));
      check({name, " cand_sel_hold"}, 32'(bus_b.cand_sel), 32'(fsel));
    end else begin
      check({name, " winner"}, 32'(bus_a.winner), 32'(win));
      check({name, " best_fit"}, 32'(bus_a.best_fit), 32'(best));
      check({name, " perfect"}, 32'(bus_a.perfect), 32'(best == 64));
      check({name, " cand_sel_hold"}, 32'(bus_a.cand_sel), 32'(fsel));
    end
  endtask

  task automatic fill_a(input logic [15:0] v);
    for (int c = 0; c < 4; c++) set_cand(0, c, v, v, v, v);
  endtask

  initial begin
    int pulses;
    fill_a(16'h0000);
    set_cand(1, 0, 16'h0, 16'h0, 16'h0, 16'h0);
    set_cand(1, 1, 16'h0, 16'h0, 16'h0, 16'h0);

    // Reset state and constant stimulus, observed while rst is still high.
    repeat (3) @(posedge clk);
    #1;
    check("rst a1", 32'(bus_a.a1), 32'h0000CCCC);
    check("rst a0", 32'(bus_a.a0), 32'h0000AAAA);
    check("rst b1", 32'(bus_a.b1), 32'h0000FF00);
    check("rst b0", 32'(bus_a.b0), 32'h0000F0F0);
    check("rst busy", 32'(bus_a.busy), 32'd0);
    check("rst done", 32'(bus_a.done), 32'd0);
    check("rst cand_sel", 32'(bus_a.cand_sel), 32'd0);
    check("rst winner", 32'(bus_a.winner), 32'd0);
    check("rst best_fit", 32'(bus_a.best_fit), 32'd0);
    check("rst perfect", 32'(bus_a.perfect), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("idle busy", 32'(bus_a.busy), 32'd0);

    // Directed rounds.
    run_round("all_zero", 0, 1'b0);
    fill_a(16'h0000); set_golden(0, 2);
    run_round("cand2_golden", 0, 1'b0);
    fill_a(16'h0000); set_golden(0, 1); set_golden(0, 3);
    run_round("tie_1_3", 0, 1'b0);
    fill_a(16'hFFFF);
    run_round("all_ones", 0, 1'b0);
    fill_a(16'hFFFF); set_cand(0, 0, golden(3), golden(2), golden(1), 16'hA0A1);
    run_round("one_bit_off", 0, 1'b0);
    fill_a(16'h0000); set_golden(0, 3);
    run_round("start_while_busy", 0, 1'b1);

    // Abort mid-round with reset asserted during cycle 5 after start.
    fill_a(16'h0000);
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    check("pre_rst cand_sel", 32'(bus_a.cand_sel), 32'd1);
    check("pre_rst best_fit", 32'(bus_a.best_fit), 32'd50);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort busy", 32'(bus_a.busy), 32'd0);
    check("abort cand_sel", 32'(bus_a.cand_sel), 32'd0);
    check("abort done", 32'(bus_a.done), 32'd0);
    check("abort best_fit", 32'(bus_a.best_fit), 32'd0);
    pulses = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(posedge clk); #1;
      if (bus_a.done) pulses++;
    end
    check("abort no_done", 32'(pulses), 32'd0);
    fill_a(16'h0000); set_golden(0, 2);
    run_round("after_abort", 0, 1'b0);

    // Randomised candidate pools.
    for (int r = 0; r < 10; r++) begin
      for (int c = 0; c < 4; c++) begin
        int mode;
        logic [15:0] v [4];
        mode = $urandom_range(0, 3);
        for (int k = 0; k < 4; k++) begin
          case (mode)
            0:       v[k] = 16'($urandom);
            3:       v[k] = 16'h0000;
            default: v[k] = golden(k);
          endcase
        end
        if (mode == 2) begin
          int flips;
          flips = $urandom_range(1, 3);
          for (int f = 0; f < flips; f++) begin
            int k;
            int b;
            k = $urandom_range(0, 3);
            b = $urandom_range(0, 15);
            v[k][b] = ~v[k][b];
          end
        end
        set_cand(0, c, v[3], v[2], v[1], v[0]);
      end
      run_round("random", 0, (r % 2) == 1);
    end

    // Single-candidate, zero-settle instance.
    set_golden(1, 0);
    run_round("n1_golden", 1, 1'b0);
    set_cand(1, 0, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
    run_round("n1_random", 1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule

// File: doc/mul4_tournament_sched.md
Name: mul4_tournament_sched

Overview:
- Sequencer and scorer for a tournament round of evolved 2-bit x 2-bit multiplier candidates.
- Each candidate is a combinational mul4 individual with the standard vector interface: inputs a1/a0/b1/b0, outputs y3..y0, all 16-bit bit-parallel truth-table lanes.
- The block drives the exhaustive stimulus vectors and selects candidates one at a time through an external mux (cand_sel).
- It scores each candidate against the golden product and reports the tournament winner.

Parameters:
- N_CAND, 4: number of candidates in the round (1..16).
- SETTLE, 1: cycles to wait after cand_sel changes before sampling y (0..15).
- IDX_W, $clog2(N_CAND) min 1: width of candidate index outputs (derived, not overridden).

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  synchronous reset, active-high.
- start  in  1  begin a round; accepted only in IDLE.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when a round completes.
- a1  out  16  stimulus 16'hCCCC (constant).
- a0  out  16  stimulus 16'hAAAA (constant).
- b1  out  16  stimulus 16'hFF00 (constant).
- b0  out  16  stimulus 16'hF0F0 (constant).
- cand_sel  out  IDX_W  index of the candidate currently routed to y3..y0.
- y3, y2, y1, y0  in  16 each  outputs of the selected candidate.
- winner  out  IDX_W  index of the best candidate; valid when done and held afterwards.
- best_fit  out  7  fitness of the winner, 0..64; held after done.
- perfect  out  1  best_fit == 64; held after done.

Behaviour:
- Lane i (0..15) encodes one test case: a = {a1[i],a0[i]}, b = {b1[i],b0[i]}.
- Golden product bits: G3 = 16'h8000, G2 = 16'h4C00, G1 = 16'h6AC0, G0 = 16'hA0A0.
- Fitness = 64 - popcount((y3^G3)|(y2^G2)<<16|(y1^G1)<<32|(y0^G0)<<48), i.e. the count of matching bits over all 64.
- Popcount is computed combinationally and registered in SAMPLE.
- FSM states: IDLE, WAIT, SAMPLE, UPDATE, DONE.
  - IDLE: on start, set cand_sel = 0, best_fit = 0, winner = 0, perfect = 0, clear the settle counter, go to WAIT.
  - WAIT: stays SETTLE cycles; with SETTLE = 0 it lasts exactly 1 cycle (pass-through).
  - SAMPLE: register the fitness of cand_sel.
  - UPDATE: if fit > best_fit, or cand_sel == 0, load best_fit/winner. If cand_sel == N_CAND-1, go to DONE; else increment cand_sel and go to WAIT.
  - DONE: done = 1 for one cycle, then IDLE.
- Per-candidate cost is max(SETTLE,1) + 2 cycles. done asserts N_CAND*(max(SETTLE,1)+2) + 1 cycles after the start cycle.
- Ties: strict greater-than, so the lowest index wins.
- start while busy or in DONE is ignored; there is no queuing.
- cand_sel holds its final value after the round until the next start.
- Reset values: busy = 0, done = 0, cand_sel = 0, winner = 0, best_fit = 0, perfect = 0, state = IDLE.
- Stimulus outputs are constant, including during reset.
- rst mid-round aborts immediately to the reset values; no done pulse.
- N_CAND = 1: a single candidate is scored and it is the winner.

Optional Feature:
- Macro: MUL4_SCHED_EARLY_EXIT_EN.
- With the macro: in UPDATE, if the sampled fit == 64, go to DONE immediately, skipping the remaining candidates; winner is that index.
- Without the macro: all N_CAND candidates are always scored, and round latency is fixed.

Test Plan:
- N_CAND=4, SETTLE=1; all candidates drive y=0 -> done at cycle 13 after start; winner=0, best_fit=50, perfect=0.
- Candidate 2 drives the golden vectors, others 0 -> winner=2, best_fit=64, perfect=1. With EARLY_EXIT_EN, done at cycle 10 instead of 13.
- Candidates 1 and 3 both golden -> winner=1 (tie goes to lowest index).
- Candidate 0 has y0 = 16'hA0A1 (1 bit wrong), others all-ones -> winner=0, best_fit=63. Check the all-ones fitness = 14.
- start pulsed again while busy -> ignored; exactly one done pulse. rst asserted on cycle 5 -> busy=0, cand_sel=0, no done; a fresh start runs normally.
- SETTLE=0 and N_CAND=1, y golden -> done at cycle 4, winner=0, best_fit=64.
